// File: rtl/rr_mem_arbiter.sv
// rtl/rr_mem_arbiter.sv - round-robin arbiter sharing one synchronous RAM port among NREQ requesters
module rr_mem_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [NREQ-1:0]      rden,
  input  logic [NREQ-1:0]      wren,
  input  logic [NREQ*AW-1:0]   Address,
  input  logic [NREQ*DW-1:0]   Din,
  input  logic [DW-1:0]        RAMq,
  output logic [NREQ-1:0]      acq,
  output logic [NREQ*DW-1:0]   Dq,
  output logic [AW-1:0]        RAMAddress,
  output logic [DW-1:0]        RAMDin,
  output logic                 RAMwren,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_grant;
  logic              r_write;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_din;
  logic [NREQ-1:0]   r_acq;
  logic              r_ramwren;
  logic              r_busy;
  logic [DW-1:0]     r_dq [NREQ];

  logic [NREQ-1:0]   w_req;
  logic              w_found;
  logic [IW-1:0]     w_pick;
  logic [AW-1:0]     w_addr_arr [NREQ];
  logic [DW-1:0]     w_din_arr  [NREQ];

  // Slot reached k steps after base in cyclic order.
  function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return s[IW-1:0];
  endfunction

  assign w_req = rden | wren;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_addr_arr[gi]        = Address[gi*AW +: AW];
    assign w_din_arr[gi]         = Din[gi*DW +: DW];
    assign Dq[gi*DW +: DW]       = r_dq[gi];
  end

  // Walk from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      if (w_req[rr_slot(r_last, k)]) begin
        w_found = 1'b1;
        w_pick  = rr_slot(r_last, k);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= IW'(NREQ - 1);
      r_grant   <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_acq     <= '0;
      r_ramwren <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        r_dq[i] <= '0;
      end
    end else begin
      r_acq     <= '0;
      r_ramwren <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant   <= w_pick;
            r_write   <= wren[w_pick];
            r_addr    <= w_addr_arr[w_pick];
            r_din     <= w_din_arr[w_pick];
            r_ramwren <= wren[w_pick];
            r_busy    <= 1'b1;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_write) begin
            r_acq   <= NREQ'(1) << r_grant;
            r_state <= ACK;
          end else begin
            r_state <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_dq[r_grant] <= RAMq;
          r_acq         <= NREQ'(1) << r_grant;
          r_state       <= ACK;
        end
        ACK: begin
          r_last  <= r_grant;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign acq        = r_acq;
  assign RAMAddress = r_addr;
  assign RAMDin     = r_din;
  assign RAMwren    = r_ramwren;
  assign busy       = r_busy;

endmodule

// File: doc/rr_mem_arbiter.md
RR_MEM_ARBITER -- requirements
Module: rr_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter AW, default 8, the RAM address width.
REQ-003 The block SHALL have parameter DW, default 8, the RAM data width.
REQ-004 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port rden  input  NREQ  per-requester read request, bit i = requester i.
REQ-007 The block SHALL have port wren  input  NREQ  per-requester write request.
REQ-008 The block SHALL have port Address  input  NREQ*AW  packed requester addresses; slice i = requester i.
REQ-009 The block SHALL have port Din  input  NREQ*DW  packed requester write data.
REQ-010 The block SHALL have port RAMq  input  DW  RAM read data, valid the cycle after the address edge.
REQ-011 The block SHALL have port acq  output  NREQ  one-cycle completion pulse per requester.
REQ-012 The block SHALL have port Dq  output  NREQ*DW  packed per-requester read data.
REQ-013 The block SHALL have port RAMAddress  output  AW  shared RAM address.
REQ-014 The block SHALL have port RAMDin  output  DW  shared RAM write data.
REQ-015 The block SHALL have port RAMwren  output  1  shared RAM write enable.
REQ-016 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 Requester i SHALL be requesting when rden[i] or wren[i] is high; if both are high, the access SHALL be a write.
REQ-018 The FSM SHALL have four states: IDLE, ACCESS, RDWAIT and ACK.
REQ-019 In IDLE with at least one request, the arbiter SHALL grant the first requesting index after last (cyclic order last+1, last+2, ...).
- In the same edge it SHALL latch grant, op, Address slice and Din slice.
- It SHALL then go to ACCESS.
- With no request it SHALL stay in IDLE.
REQ-020 In ACCESS, RAMAddress and RAMDin SHALL drive the latched values, and RAMwren SHALL be high only for a write.
- Next state SHALL be ACK for a write and RDWAIT for a read.
REQ-021 In RDWAIT, RAMq SHALL be captured into Dq slice grant at the end of the cycle; next state SHALL be ACK.
REQ-022 In ACK, acq[grant] SHALL be high for exactly one cycle, last SHALL be set to grant, and next state SHALL be IDLE.
REQ-023 acq SHALL be one-hot or zero at all times.
REQ-024 RAMwren SHALL be low in every state except ACCESS-with-write.
REQ-025 RAMAddress and RAMDin SHALL hold their latched values outside ACCESS.
REQ-026 Latency from a request first sampled in IDLE SHALL be acq in cycle +2 for a write and cycle +3 for a read.
- For a read, Dq SHALL be valid in the same cycle as acq.
REQ-027 Dq slice i SHALL hold its value until the next completed read by requester i; other slices SHALL be unaffected.
REQ-028 Requests SHALL NOT be sampled outside IDLE.
- Changes to the granted requester's inputs after grant SHALL NOT affect the transaction in flight.
- A request dropped before ACK SHALL still complete and pulse acq.
REQ-029 Each continuously requesting requester SHALL be served within NREQ transactions of first being sampled (no starvation).
REQ-030 A requester holding its request after acq SHALL be re-arbitrated as a new transaction, at lowest priority relative to the others.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL set:
- state = IDLE, last = NREQ-1 (requester 0 has first priority);
- acq = 0, Dq = 0, RAMAddress = 0, RAMDin = 0, RAMwren = 0, busy = 0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no acq pulse, and RAMwren SHALL be low from the cycle after the reset edge.

Verification
REQ-033 After reset, requester 2 writes 0xA5 to address 0x10 -> RAMwren=1, RAMAddress=0x10, RAMDin=0xA5 in cycle +1; acq=4'b0100 in cycle +2 only.
REQ-034 Requester 1 reads address 0x10 holding 0xA5 -> acq=4'b0010 in cycle +3; Dq[15:8]=0xA5; other Dq slices unchanged.
REQ-035 All four requesters request continuously from reset -> grant order 0,1,2,3,0; each acq appears exactly once per four transactions.
REQ-036 rden[3] and wren[3] both high -> write performed (RAMwren=1); Dq[31:24] unchanged.
REQ-037 rst pulsed in the RDWAIT of requester 0's read -> no acq pulse, busy=0 and Dq=0 next cycle; the next grant goes to the lowest requesting index.
REQ-038 Requester 1 drops rden in ACCESS -> transaction still completes with acq[1] pulsed; no further grant to requester 1.
